// File: rtl/servo_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// +--------------------------------------------------------------------------+
// | Module   : servo_pkg                                                     |
// | Purpose  : Shared state encoding and default timing constants for the    |
// |            servo pickup/dropoff sequencer and its PWM generator.         |
// | Ports    : none (package)                                               |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
//------------------------------------------------------------------------------
package servo_pkg;

   // Sequencer states. Explicit 3-bit encoding keeps the state register
   // width stable regardless of how many states are added later.
   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_MOVE_OUT  = 3'd1,
      ST_DWELL     = 3'd2,
      ST_MOVE_BACK = 3'd3,
      ST_DONE      = 3'd4
   } state_t;

   // Defaults assume a 50 MHz clock and a standard 50 Hz hobby servo.
   localparam int unsigned c_DEF_FRAME_CYCLES = 1000000; // 20 ms frame
   localparam int unsigned c_DEF_HOME_W       = 75000;   // 1.5 ms
   localparam int unsigned c_DEF_PICK_W       = 50000;   // 1.0 ms
   localparam int unsigned c_DEF_DROP_W       = 100000;  // 2.0 ms
   localparam int unsigned c_DEF_STEP_W       = 2500;    // max change per frame
   localparam int unsigned c_DEF_DWELL_FRAMES = 25;      // 0.5 s hold

endpackage : servo_pkg
`default_nettype wire

// File: rtl/servo_pwm.sv
`default_nettype none
//------------------------------------------------------------------------------
// +--------------------------------------------------------------------------+
// | Module   : servo_pwm                                                     |
// | Purpose  : Free-running frame counter plus width comparator producing   |
// |            the servo PWM waveform and a per-frame boundary strobe.       |
// | Ports    : clk        - clock, rising edge                               |
// |            reset      - synchronous active-high reset                    |
// |            width      - pulse width in clk cycles (held stable by the    |
// |                         caller except on the frame_tick cycle)           |
// |            pwm_out    - registered PWM drive                             |
// |            frame_tick - high on the last cycle of each frame             |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
//------------------------------------------------------------------------------
module servo_pwm
   import servo_pkg::*;
#(
   parameter int unsigned FRAME_CYCLES = c_DEF_FRAME_CYCLES
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [$clog2(FRAME_CYCLES)-1:0] width,
   output logic                            pwm_out,
   output logic                            frame_tick
);

   localparam int unsigned c_CW = $clog2(FRAME_CYCLES);
   localparam logic [c_CW-1:0] c_LAST = c_CW'(FRAME_CYCLES - 1);

   logic [c_CW-1:0] r_frame_cnt;

   // Boundary strobe is decoded from the registered count, so it is glitch
   // free and lines up with the cycle on which the count wraps.
   assign frame_tick = (r_frame_cnt == c_LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_frame_cnt <= '0;
         pwm_out     <= 1'b0;
      end else begin
         // The caller only changes width on the wrap cycle; by then the
         // comparison of the last count against the old width has already
         // been taken, so every frame sees one width from start to end.
         pwm_out <= (r_frame_cnt < width);
         if (frame_tick) begin
            r_frame_cnt <= '0;
         end else begin
            r_frame_cnt <= r_frame_cnt + 1'b1;
         end
      end
   end

endmodule : servo_pwm
`default_nettype wire

// File: rtl/servo_sequencer.sv
`default_nettype none
//------------------------------------------------------------------------------
// +--------------------------------------------------------------------------+
// | Module   : servo_sequencer                                               |
// | Purpose  : Runs one pickup or dropoff routine per request: ramp the      |
// |            servo from home to the selected position, hold it for a       |
// |            number of frames, ramp back home and pulse servo_done.        |
// | Ports    : clk         - clock, rising edge                              |
// |            reset       - synchronous active-high reset                   |
// |            servo_req   - level request; must fall before re-arming       |
// |            servo_state - routine select, 1 = pickup, 0 = dropoff         |
// |            servo_done  - one-cycle routine-complete pulse                |
// |            busy        - high while a routine is in progress             |
// |            pwm_out     - servo PWM drive                                 |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
//------------------------------------------------------------------------------
module servo_sequencer
   import servo_pkg::*;
#(
   parameter int unsigned FRAME_CYCLES = c_DEF_FRAME_CYCLES,
   parameter int unsigned HOME_W       = c_DEF_HOME_W,
   parameter int unsigned PICK_W       = c_DEF_PICK_W,
   parameter int unsigned DROP_W       = c_DEF_DROP_W,
   parameter int unsigned STEP_W       = c_DEF_STEP_W,
   parameter int unsigned DWELL_FRAMES = c_DEF_DWELL_FRAMES
) (
   input  logic clk,
   input  logic reset,
   input  logic servo_req,
   input  logic servo_state,
   output logic servo_done,
   output logic busy,
   output logic pwm_out
);

   localparam int unsigned c_CW = $clog2(FRAME_CYCLES);
   localparam logic [c_CW-1:0] c_HOME = c_CW'(HOME_W);
   localparam logic [c_CW-1:0] c_PICK = c_CW'(PICK_W);
   localparam logic [c_CW-1:0] c_DROP = c_CW'(DROP_W);
   // Only used when the distance exceeds STEP_W, which bounds STEP_W below
   // the counter range, so the truncating cast never loses bits in use.
   localparam logic [c_CW-1:0] c_STEP = c_CW'(STEP_W);

   // A dwell of zero frames behaves like a dwell of one frame.
   localparam int unsigned c_DW = (DWELL_FRAMES > 1) ? $clog2(DWELL_FRAMES) : 1;
   localparam logic [c_DW-1:0] c_DWELL_LAST =
      c_DW'((DWELL_FRAMES > 0) ? (DWELL_FRAMES - 1) : 0);

   state_t          r_state;
   logic            r_mode;
   logic            r_armed;
   logic [c_CW-1:0] r_cur_w;
   logic [c_DW-1:0] r_dwell_cnt;

   logic [c_CW-1:0] w_target;
   logic [c_CW-1:0] w_next_w;
   logic [c_CW-1:0] w_diff;
   logic            w_frame_tick;

   //---------------------------------------------------------------------------
   // Target and single-frame ramp step.
   // The target is home once the routine heads back; otherwise it follows the
   // latched mode. The step lands exactly on the target whenever the remaining
   // distance fits in one step, so the ramp never overshoots and a zero
   // distance completes in a single frame.
   //---------------------------------------------------------------------------
   always_comb begin
      w_target = (r_state == ST_MOVE_BACK) ? c_HOME : (r_mode ? c_PICK : c_DROP);
      w_diff   = '0;
      w_next_w = w_target;
      if (r_cur_w > w_target) begin
         w_diff = r_cur_w - w_target;
         if (32'(w_diff) > STEP_W) begin
            w_next_w = r_cur_w - c_STEP;
         end
      end else begin
         w_diff = w_target - r_cur_w;
         if (32'(w_diff) > STEP_W) begin
            w_next_w = r_cur_w + c_STEP;
         end
      end
   end

   //---------------------------------------------------------------------------
   // Routine sequencer. Width changes are made only on frame_tick so the PWM
   // generator never sees a width change mid-frame.
   //---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_mode      <= 1'b0;
         r_armed     <= 1'b1;
         r_cur_w     <= c_HOME;
         r_dwell_cnt <= '0;
         servo_done  <= 1'b0;
         busy        <= 1'b0;
      end else begin
         servo_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (servo_req && r_armed) begin
                  r_mode  <= servo_state;
                  busy    <= 1'b1;
                  r_state <= ST_MOVE_OUT;
               end else if (!servo_req) begin
                  // Re-arm only after the requester has dropped its level,
                  // so a request held across completion cannot retrigger.
                  r_armed <= 1'b1;
               end
            end

            ST_MOVE_OUT: begin
               if (w_frame_tick) begin
                  r_cur_w <= w_next_w;
                  if (w_next_w == w_target) begin
                     r_dwell_cnt <= '0;
                     r_state     <= ST_DWELL;
                  end
               end
            end

            ST_DWELL: begin
               if (w_frame_tick) begin
                  if (r_dwell_cnt == c_DWELL_LAST) begin
                     r_dwell_cnt <= '0;
                     r_state     <= ST_MOVE_BACK;
                  end else begin
                     r_dwell_cnt <= r_dwell_cnt + 1'b1;
                  end
               end
            end

            ST_MOVE_BACK: begin
               if (w_frame_tick) begin
                  r_cur_w <= w_next_w;
                  if (w_next_w == w_target) begin
                     r_state <= ST_DONE;
                  end
               end
            end

            ST_DONE: begin
               servo_done <= 1'b1;
               busy       <= 1'b0;
               r_armed    <= 1'b0;
               r_state    <= ST_IDLE;
            end

            default: begin
               r_state <= ST_IDLE;
               busy    <= 1'b0;
            end
         endcase
      end
   end

   servo_pwm #(
      .FRAME_CYCLES (FRAME_CYCLES)
   ) u_pwm (
      .clk        (clk),
      .reset      (reset),
      .width      (r_cur_w),
      .pwm_out    (pwm_out),
      .frame_tick (w_frame_tick)
   );

endmodule : servo_sequencer
`default_nettype wire

// File: tb/tb_servo_sequencer.sv
`default_nettype none
//------------------------------------------------------------------------------
// +--------------------------------------------------------------------------+
// | Module   : tb_servo_sequencer                                            |
// | Purpose  : Self-checking bench for servo_sequencer. Two instances share  |
// |            stimulus: one ramps 5 per frame, the other 15 per frame.      |
// | Ports    : none                                                          |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
//------------------------------------------------------------------------------
module tb_servo_sequencer;

   localparam int FC    = 100;
   localparam int HOME  = 30;
   localparam int PICK  = 20;
   localparam int DROP  = 40;
   localparam int DWELL = 2;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic servo_req = 1'b0;
   logic servo_state = 1'b0;
   logic done0, busy0, pwm0, done1, busy1, pwm1;
   logic [1:0] pwm_v, busy_v, done_v;

   assign pwm_v  = {pwm1, pwm0};
   assign busy_v = {busy1, busy0};
   assign done_v = {done1, done0};

   initial forever #5 clk = ~clk;

   servo_sequencer #(
      .FRAME_CYCLES(FC), .HOME_W(HOME), .PICK_W(PICK), .DROP_W(DROP),
      .STEP_W(5), .DWELL_FRAMES(DWELL)
   ) dut0 (
      .clk(clk), .reset(reset), .servo_req(servo_req), .servo_state(servo_state),
      .servo_done(done0), .busy(busy0), .pwm_out(pwm0)
   );

   servo_sequencer #(
      .FRAME_CYCLES(FC), .HOME_W(HOME), .PICK_W(PICK), .DROP_W(DROP),
      .STEP_W(15), .DWELL_FRAMES(DWELL)
   ) dut1 (
      .clk(clk), .reset(reset), .servo_req(servo_req), .servo_state(servo_state),
      .servo_done(done1), .busy(busy1), .pwm_out(pwm1)
   );

   int n_cmp = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         if (n_fail <= 40)
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   //---------------------------------------------------------------------------
   // Behavioural model: on acceptance, the whole routine is planned as a list
   // of per-frame widths; one entry is applied at each frame boundary.
   //---------------------------------------------------------------------------
   int m_cnt [2];
   int m_w [2];
   int plan [2][64];
   int plan_len [2];
   int plan_pos [2];
   bit m_pwm [2];
   bit m_busy [2];
   bit m_done [2];
   bit m_armed [2];
   bit m_run [2];
   bit m_finish [2];

   function automatic int step_of(input int i);
      return (i == 0) ? 5 : 15;
   endfunction

   function automatic int toward(input int w, input int t, input int s);
      if (t > w) return (t - w <= s) ? t : w + s;
      return (w - t <= s) ? t : w - s;
   endfunction

   task automatic build_plan(input int i, input int tgt);
      int w;
      int n;
      w = m_w[i];
      n = 0;
      do begin
         w = toward(w, tgt, step_of(i));
         plan[i][n] = w;
         n++;
      end while (w != tgt);
      for (int k = 0; k < DWELL; k++) begin
         plan[i][n] = tgt;
         n++;
      end
      do begin
         w = toward(w, HOME, step_of(i));
         plan[i][n] = w;
         n++;
      end while (w != HOME);
      plan_len[i] = n;
      plan_pos[i] = 0;
   endtask

   initial forever begin
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
         if (reset) begin
            m_cnt[i] = 0; m_w[i] = HOME; m_pwm[i] = 1'b0; m_busy[i] = 1'b0;
            m_done[i] = 1'b0; m_armed[i] = 1'b1; m_run[i] = 1'b0; m_finish[i] = 1'b0;
            plan_len[i] = 0; plan_pos[i] = 0;
         end else begin
            bit bnd;
            m_pwm[i] = (m_cnt[i] < m_w[i]);
            bnd = (m_cnt[i] == FC - 1);
            m_done[i] = 1'b0;
            if (m_finish[i]) begin
               m_done[i] = 1'b1; m_busy[i] = 1'b0; m_armed[i] = 1'b0;
               m_run[i] = 1'b0; m_finish[i] = 1'b0;
            end else if (!m_run[i]) begin
               if (servo_req && m_armed[i]) begin
                  build_plan(i, servo_state ? PICK : DROP);
                  m_run[i] = 1'b1;
                  m_busy[i] = 1'b1;
               end else if (!servo_req) begin
                  m_armed[i] = 1'b1;
               end
            end else if (bnd) begin
               m_w[i] = plan[i][plan_pos[i]];
               plan_pos[i]++;
               if (plan_pos[i] == plan_len[i]) m_finish[i] = 1'b1;
            end
            m_cnt[i] = bnd ? 0 : m_cnt[i] + 1;
         end
      end
   end

   //---------------------------------------------------------------------------
   // Per-cycle compare plus pulse-run and done-pulse bookkeeping.
   //---------------------------------------------------------------------------
   int runs [2][64];
   int run_n [2];
   int run_len [2];
   bit prev_pwm [2];
   int done_cnt [2];

   initial begin
      for (int i = 0; i < 2; i++) begin
         run_n[i] = 0; run_len[i] = 0; prev_pwm[i] = 1'b0; done_cnt[i] = 0;
      end
   end

   initial forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         if (chk_en) begin
            check($sformatf("pwm[%0d]", i), int'(pwm_v[i]), int'(m_pwm[i]));
            check($sformatf("busy[%0d]", i), int'(busy_v[i]), int'(m_busy[i]));
            check($sformatf("done[%0d]", i), int'(done_v[i]), int'(m_done[i]));
         end
         if (pwm_v[i] === 1'b1) begin
            run_len[i]++;
         end else if (prev_pwm[i]) begin
            if (run_n[i] < 64) runs[i][run_n[i]] = run_len[i];
            run_n[i]++;
            run_len[i] = 0;
         end
         prev_pwm[i] = (pwm_v[i] === 1'b1);
         if (done_v[i] === 1'b1) done_cnt[i]++;
      end
   end

   //---------------------------------------------------------------------------
   // Directed scenarios
   //---------------------------------------------------------------------------
   task automatic wait_runs(input int i, input int n, input int bound, input string name);
      int c = 0;
      while (run_n[i] < n && c < bound) begin
         @(negedge clk);
         c++;
      end
      check(name, int'(run_n[i] >= n), 1);
   endtask

   task automatic wait_done(input int d0, input int d1, input string name);
      int c = 0;
      while ((done_cnt[0] <= d0 || done_cnt[1] <= d1) && c < 3000) begin
         @(negedge clk);
         c++;
      end
      check(name, int'(done_cnt[0] > d0 && done_cnt[1] > d1), 1);
   endtask

   // Park just after a pulse has ended so the next recorded pulse is the
   // first frame following the next boundary.
   task automatic align_and_clear();
      wait_runs(0, run_n[0] + 1, 2 * FC, "align");
      repeat (10) @(negedge clk);
      run_n[0] = 0;
      run_n[1] = 0;
   endtask

   task automatic check_runs(input int i, input int exp [6], input int n, input string name);
      for (int k = 0; k < n; k++)
         check($sformatf("%s[%0d].frame%0d", name, i, k), runs[i][k], exp[k]);
   endtask

   int d0, d1;
   int e_pick0 [6] = '{25, 20, 20, 20, 25, 30};
   int e_pick1 [6] = '{20, 20, 20, 30, 0, 0};
   int e_drop0 [6] = '{35, 40, 40, 40, 35, 30};
   int e_drop1 [6] = '{40, 40, 40, 30, 0, 0};

   initial begin
      // Reset state
      @(posedge clk);
      chk_en = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_busy", int'(busy0), 0);
      check("rst_pwm", int'(pwm0), 0);
      check("rst_done", int'(done0), 0);
      reset = 1'b0;

      // Idle: every frame is home width, no done pulses
      repeat (350) @(negedge clk);
      check("idle_nruns", int'(run_n[0] >= 3), 1);
      for (int k = 0; k < 3; k++) begin
         check($sformatf("idle[0].frame%0d", k), runs[0][k], HOME);
         check($sformatf("idle[1].frame%0d", k), runs[1][k], HOME);
      end
      check("idle_done_cnt", done_cnt[0] + done_cnt[1], 0);
      check("idle_busy", int'(busy0), 0);

      // Pickup
      align_and_clear();
      d0 = done_cnt[0]; d1 = done_cnt[1];
      servo_state = 1'b1;
      servo_req = 1'b1;
      repeat (5) @(negedge clk);
      servo_req = 1'b0;
      wait_done(d0, d1, "pick_done_seen");
      repeat (2 * FC) @(negedge clk);
      check_runs(0, e_pick0, 6, "pick");
      check_runs(1, e_pick1, 4, "pick");
      check("pick_done_cnt0", done_cnt[0] - d0, 1);
      check("pick_done_cnt1", done_cnt[1] - d1, 1);
      check("pick_busy_after", int'(busy0), 0);

      // Dropoff, with servo_state toggled mid-routine
      align_and_clear();
      d0 = done_cnt[0]; d1 = done_cnt[1];
      servo_state = 1'b0;
      servo_req = 1'b1;
      repeat (5) @(negedge clk);
      servo_req = 1'b0;
      repeat (250) @(negedge clk);
      servo_state = 1'b1;
      wait_done(d0, d1, "drop_done_seen");
      repeat (2 * FC) @(negedge clk);
      check_runs(0, e_drop0, 6, "drop");
      check_runs(1, e_drop1, 4, "drop");
      check("drop_done_cnt0", done_cnt[0] - d0, 1);
      check("drop_busy_after", int'(busy0), 0);

      // Request held through completion must not retrigger
      align_and_clear();
      d0 = done_cnt[0]; d1 = done_cnt[1];
      servo_state = 1'b1;
      servo_req = 1'b1;
      wait_done(d0, d1, "hold_done_seen");
      repeat (500) @(negedge clk);
      check("hold_no_retrigger_busy", int'(busy0), 0);
      check("hold_done_cnt0", done_cnt[0] - d0, 1);
      servo_req = 1'b0;
      @(negedge clk);
      servo_req = 1'b1;
      repeat (3) @(negedge clk);
      check("rearm_busy", int'(busy0), 1);
      servo_req = 1'b0;
      d0 = done_cnt[0]; d1 = done_cnt[1];
      wait_done(d0, d1, "rearm_done_seen");
      repeat (FC) @(negedge clk);

      // Reset while dwelling
      align_and_clear();
      d0 = done_cnt[0]; d1 = done_cnt[1];
      servo_state = 1'b1;
      servo_req = 1'b1;
      repeat (5) @(negedge clk);
      servo_req = 1'b0;
      wait_runs(0, 3, 6 * FC, "dwell_reached");
      check("dwell_busy", int'(busy0), 1);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      check("midrst_busy0", int'(busy0), 0);
      check("midrst_pwm0", int'(pwm0), 0);
      check("midrst_busy1", int'(busy1), 0);
      reset = 1'b0;
      run_n[0] = 0;
      run_n[1] = 0;
      wait_runs(0, 1, 2 * FC, "midrst_frame_seen");
      check("midrst_frame0", runs[0][0], HOME);
      check("midrst_frame1", runs[1][0], HOME);
      repeat (5 * FC) @(negedge clk);
      check("midrst_no_done0", done_cnt[0] - d0, 0);
      check("midrst_no_done1", done_cnt[1] - d1, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule : tb_servo_sequencer
`default_nettype wire

// File: doc/servo_sequencer.md
SERVO_SEQUENCER -- requirements
Module: servo_sequencer

Interface
REQ-001 SHALL have parameter FRAME_CYCLES, default 1000000, PWM frame length in clk cycles (20 ms at 50 MHz).
REQ-002 SHALL have parameter HOME_W, default 75000, home pulse width in cycles (1.5 ms).
REQ-003 SHALL have parameter PICK_W, default 50000, pickup-position pulse width (1.0 ms).
REQ-004 SHALL have parameter DROP_W, default 100000, dropoff-position pulse width (2.0 ms).
REQ-005 SHALL have parameter STEP_W, default 2500, maximum pulse-width change per frame.
REQ-006 SHALL have parameter DWELL_FRAMES, default 25, frames held at the target position.
REQ-007 SHALL have port clk, input, 1 bit: the only clock; all logic on its rising edge.
REQ-008 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-009 SHALL have port servo_req, input, 1 bit: level request from the rover flag FSM.
REQ-010 SHALL have port servo_state, input, 1 bit: routine select, 1 = pickup, 0 = dropoff.
REQ-011 SHALL have port servo_done, output, 1 bit: one-cycle routine-complete pulse.
REQ-012 SHALL have port busy, output, 1 bit: high while a routine is in progress.
REQ-013 SHALL have port pwm_out, output, 1 bit: servo PWM drive.

Function
REQ-014 SHALL count frame_cnt from 0 to FRAME_CYCLES-1 and wrap; a frame boundary is the cycle where frame_cnt = FRAME_CYCLES-1.
REQ-015 SHALL drive pwm_out = (frame_cnt < cur_w), registered; pulse width is updated only at a frame boundary, so no frame carries a partial pulse.
REQ-016 SHALL use states IDLE, MOVE_OUT, DWELL, MOVE_BACK and DONE.
REQ-017 IDLE: when servo_req = 1 and armed = 1, SHALL latch servo_state into mode, set target to PICK_W (mode 1) or DROP_W (mode 0), and enter MOVE_OUT on the next cycle; busy rises in the same cycle as the transition.
REQ-018 MOVE_OUT: at each frame boundary, SHALL set cur_w to target if |target-cur_w| <= STEP_W, else to cur_w ± STEP_W toward target; when cur_w = target at a boundary, SHALL enter DWELL.
REQ-019 DWELL: SHALL count DWELL_FRAMES frame boundaries, then set target = HOME_W and enter MOVE_BACK.
REQ-020 MOVE_BACK: SHALL ramp as in REQ-018 toward HOME_W; when cur_w = HOME_W at a boundary, SHALL enter DONE.
REQ-021 DONE: SHALL assert servo_done for exactly one cycle, clear busy, clear armed, and return to IDLE.
REQ-022 armed SHALL be set only while in IDLE with servo_req = 0; a request held high across servo_done SHALL NOT retrigger.
REQ-023 servo_req and servo_state changes after the start latch SHALL be ignored until DONE (no abort).
REQ-024 Arithmetic SHALL be unsigned, with width $clog2(FRAME_CYCLES); the ramp SHALL never overshoot the target; target = cur_w SHALL pass through MOVE_OUT in one frame.

Reset
REQ-025 While reset = 1: state = IDLE, frame_cnt = 0, cur_w = HOME_W, dwell count = 0, armed = 1, servo_done = 0, busy = 0, pwm_out = 0.
REQ-026 Reset mid-routine SHALL abandon the routine with no servo_done pulse; the first frame after reset is emitted at HOME_W.

Structure
REQ-027 State encodings and default width constants SHALL live in shared package servo_pkg.
REQ-028 The frame counter and comparator SHALL be sub-module servo_pwm (inputs clk, reset, width; outputs pwm_out, frame_tick); the sequencer FSM stays in servo_sequencer.

Verification (FRAME_CYCLES=100, HOME_W=30, PICK_W=20, DROP_W=40, STEP_W=5, DWELL_FRAMES=2)
REQ-029 Idle after reset -> pwm_out high for exactly 30 of every 100 cycles; busy = 0; servo_done never pulses.
REQ-030 servo_req = 1, servo_state = 1 -> widths 25, 20, then 20 for 2 dwell frames, then 25, 30; exactly one servo_done pulse; busy low afterwards.
REQ-031 servo_req = 1, servo_state = 0 -> widths 35, 40, dwell, 35, 30; one servo_done pulse; servo_state toggled mid-routine has no effect.
REQ-032 servo_req held high through servo_done -> no second routine; drop servo_req for 1 cycle then raise it -> new routine starts.
REQ-033 reset asserted during DWELL -> busy = 0 and pwm_out = 0 during reset; the next frame is 30 wide; no servo_done pulse.
REQ-034 With STEP_W = 15 and pickup selected -> widths 20, dwell, 30 (single-frame moves, no overshoot).
